cover_toggle_drain: RTL
=======================

Name: cover_toggle_drain

Overview:
- Collector on the receiving side of the toggle-coverage reporting path.
- Samples a per-cycle vector of toggle-cover valid bits and records each bit as a sticky hit.
- Streams every newly hit cover index, exactly once and lowest index first, over a valid/ready interface to the host coverage reader.
- Keeps a running distinct-hit count and supports a handshake-safe clear. Used in place of the DPI call path in synthesizable and FPGA builds.

Parameters:
- WIDTH, 40, number of cover points in the group (1..256)
- COVER_INDEX, 0, global index of bit 0; out_index = COVER_INDEX + bit position
- COVER_TOTAL, 38253, total cover points in the design; informational only, no logic depends on it
- COUNT_W, 6, hit_count width; must satisfy 2^COUNT_W > WIDTH

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- valid  in  WIDTH  per-cycle cover-hit strobes; sampled every rising edge while not in CLEAR
- clear  in  1  single-cycle request to wipe all hit state
- out_valid  out  1  out_index holds a newly hit cover index
- out_ready  in  1  host accepts the current beat
- out_index  out  64  global cover index (zero-extended)
- hit_count  out  COUNT_W  number of distinct bits hit since the last reset or clear
- all_hit  out  1  high when hit_count == WIDTH
- busy  out  1  high in CLR_WAIT or CLEAR

Behaviour:
- Reset (reset low, asynchronous):
  - hit, reported, hit_count, out_valid and out_index all go to 0.
  - State goes to RUN; all_hit=0, busy=0.
- Internal registers: hit[WIDTH] and reported[WIDTH], both sticky; pending = hit & ~reported.
- Capture, in RUN and CLR_WAIT:
  - hit <= hit | valid.
  - hit_count <= hit_count + popcount(valid & ~hit); never wraps, saturates at WIDTH by construction.
  - Re-toggling a bit that is already hit has no effect.
- Output register load: when out_valid==0, or out_valid && out_ready:
  - If state is RUN and pending != 0: out_index <= COVER_INDEX + lowest set bit of pending, set that bit in reported, out_valid <= 1.
  - Otherwise out_valid <= 0.
- Latency and throughput:
  - valid[i] high in cycle c sets hit[i] at edge c.
  - Index i is presented after edge c+1 at the earliest.
  - One index per cycle while out_ready stays high.
- Handshake rules:
  - While out_valid && !out_ready, out_valid and out_index hold stable.
  - An accept and a reload of the next index happen on the same edge.
  - out_valid never depends combinationally on out_ready.
- Simultaneous hits: several bits set in one cycle are all captured and emitted in ascending index order on later beats.
- State machine (RUN, CLR_WAIT, CLEAR):
  - RUN + clear, with out_valid==0 or out_ready==1 -> CLEAR; any beat accepted on that edge completes normally.
  - RUN + clear, with out_valid && !out_ready -> CLR_WAIT.
  - CLR_WAIT: no new loads; hits are still captured; on out_ready -> CLEAR.
  - CLEAR (one cycle): hit, reported and hit_count go to 0; out_valid=0; valid is ignored in this cycle; next state RUN.
  - clear asserted in CLR_WAIT or CLEAR is ignored.
- Boundary cases:
  - WIDTH=1 is legal; the lowest-bit select degenerates to bit 0.
  - COVER_INDEX + WIDTH-1 is computed in 64 bits with no overflow check.
  - After all bits are reported, out_valid stays 0 until clear.

Test Plan:
- Reset then valid=bit5 for 1 cycle, out_ready=1 -> single beat out_index=COVER_INDEX+5 two edges later; hit_count=1; no repeat when bit5 toggles again.
- COVER_INDEX=1000, valid=0x8000000003 in one cycle, out_ready=1 -> beats 1000, 1001, 1039 on consecutive cycles; hit_count=3.
- Same stimulus with out_ready=0 for 4 cycles -> out_index holds 1000 and out_valid stays high; after out_ready=1, beats 1000, 1001, 1039 in order.
- Drive all 40 bits over several cycles -> exactly 40 beats, each index once; all_hit=1; hit_count=40.
- Pending beat with out_ready=0, pulse clear -> busy=1, beat held; out_ready=1 -> beat accepted, CLEAR, hit_count=0; valid=bit5 then yields index 5 again.
- Assert reset low mid-stream, asynchronously between edges -> out_valid=0 and hit_count=0 immediately; after release, prior hits are not re-emitted.

Source files
------------

// File: rtl/cover_toggle_drain.sv
// rtl/cover_toggle_drain.sv - toggle-cover hit collector streaming each newly hit index once
module cover_toggle_drain #(
  parameter int          WIDTH       = 40,
  parameter logic [63:0] COVER_INDEX = 64'd0,
  parameter int          COVER_TOTAL = 38253,
  parameter int          COUNT_W     = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   valid,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_index,
  output logic [COUNT_W-1:0] hit_count,
  output logic               all_hit,
  output logic               busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CLR_WAIT = 2'd1,
    CLEAR    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hit_q, hit_d;
  logic [WIDTH-1:0]   reported_q, reported_d;
  logic [COUNT_W-1:0] hit_count_q, hit_count_d;
  logic               out_valid_q, out_valid_d;
  logic [63:0]        out_index_q, out_index_d;

  logic [WIDTH-1:0]   pending;
  logic [WIDTH-1:0]   new_bits;
  logic [COUNT_W-1:0] new_count;
  logic [IDX_W-1:0]   sel;
  logic               slot_free;

  // Lowest pending bit and number of first-time hits this cycle.
  always_comb begin
    pending   = hit_q & ~reported_q;
    new_bits  = valid & ~hit_q;
    new_count = '0;
    sel       = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) sel = IDX_W'(i);
    end
    for (int i = 0; i < WIDTH; i++) begin
      new_count = new_count + COUNT_W'(new_bits[i]);
    end
    slot_free = !out_valid_q || out_ready;
  end

  // Next-state: capture, output load and the clear handshake.
  always_comb begin
    state_d     = state_q;
    hit_d       = hit_q;
    reported_d  = reported_q;
    hit_count_d = hit_count_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    case (state_q)
      RUN: begin
        hit_d       = hit_q | valid;
        hit_count_d = hit_count_q + new_count;
        if (clear && slot_free) begin
          // Going straight to CLEAR: do not load a beat that would be wiped.
          state_d     = CLEAR;
          out_valid_d = 1'b0;
        end else begin
          if (clear) state_d = CLR_WAIT;
          if (slot_free) begin
            if (pending != '0) begin
              out_index_d     = COVER_INDEX + 64'(sel);
              reported_d[sel] = 1'b1;
              out_valid_d     = 1'b1;
            end else begin
              out_valid_d = 1'b0;
            end
          end
        end
      end
      CLR_WAIT: begin
        hit_d       = hit_q | valid;
        hit_count_d = hit_count_q + new_count;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        hit_d       = '0;
        reported_d  = '0;
        hit_count_d = '0;
        out_valid_d = 1'b0;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      hit_q       <= '0;
      reported_q  <= '0;
      hit_count_q <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      reported_q  <= reported_d;
      hit_count_q <= hit_count_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign hit_count = hit_count_q;
  assign all_hit   = (hit_count_q == COUNT_W'(WIDTH));
  assign busy      = (state_q != RUN);

endmodule
